// File: rtl/mbc_pkg.sv
// Shared definitions for the bus-controller power sequencer: state encoding,
// gate/isolate/reset output codes and the settle counter width.
package mbc_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_REL_RST = 3'd2,
        ST_ON      = 3'd3,
        ST_ISO     = 3'd4,
        ST_RST     = 3'd5
    } state_t;

    // {MBC_SLEEP, MBC_ISOLATE, MBC_RESET}
    localparam logic [2:0] OUT_OFF     = 3'b111;
    localparam logic [2:0] OUT_SETTLE  = 3'b011;
    localparam logic [2:0] OUT_REL_RST = 3'b010;
    localparam logic [2:0] OUT_ON      = 3'b000;
    localparam logic [2:0] OUT_ISO     = 3'b010;
    localparam logic [2:0] OUT_RST     = 3'b011;

    function automatic logic [2:0] gate_ctrl(input state_t st);
        logic [2:0] code;
        code = OUT_OFF;
        case (st)
            ST_OFF:     code = OUT_OFF;
            ST_SETTLE:  code = OUT_SETTLE;
            ST_REL_RST: code = OUT_REL_RST;
            ST_ON:      code = OUT_ON;
            ST_ISO:     code = OUT_ISO;
            ST_RST:     code = OUT_RST;
            default:    code = OUT_OFF;
        endcase
        return code;
    endfunction

    function automatic logic is_busy(input state_t st);
        return (st != ST_ON) && (st != ST_OFF);
    endfunction

endpackage

// File: rtl/mbc_power_seq.sv
// Power-gating sequencer for the bus-controller domain. Optional bus-activity
// wake is enabled by defining MBC_POWER_SEQ_WAKE_ON_BUS_EN.
//
// state    | meaning
// ---------+----------------------------------------------------
// OFF      | domain gated, isolated and held in reset
// SETTLE   | header on, waiting SETTLE_CYCLES for the rail to settle
// REL_RST  | domain reset released, outputs still isolated
// ON       | domain fully powered and connected
// ISO      | isolation applied ahead of power-down
// RST      | domain reset asserted, header about to gate
module mbc_power_seq
    import mbc_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic SLEEP_REQ,
    input  logic WAKEUP_REQ,
    input  logic WAKE_BUS,
    output logic MBC_SLEEP,
    output logic MBC_ISOLATE,
    output logic MBC_RESET,
    output logic POWER_ON,
    output logic BUSY
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             wake;

`ifdef MBC_POWER_SEQ_WAKE_ON_BUS_EN
    assign wake = WAKEUP_REQ | WAKE_BUS;
`else
    logic unused_wake_bus;
    assign unused_wake_bus = WAKE_BUS;
    assign wake            = WAKEUP_REQ;
`endif

    // Requests are only looked at in ON and OFF, so any sequence in flight
    // always completes before the levels are re-evaluated.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_OFF: begin
                if (wake) begin
                    state_next = ST_SETTLE;
                    cnt_next   = CNT_W'(SETTLE_CYCLES - 1);
                end
            end
            ST_SETTLE: begin
                if (cnt == '0) state_next = ST_REL_RST;
                else           cnt_next   = cnt - 1'b1;
            end
            ST_REL_RST: state_next = ST_ON;
            ST_ON:      if (SLEEP_REQ) state_next = ST_ISO;
            ST_ISO:     state_next = ST_RST;
            ST_RST:     state_next = ST_OFF;
            default:    state_next = ST_OFF;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state                                <= ST_OFF;
            cnt                                  <= '0;
            {MBC_SLEEP, MBC_ISOLATE, MBC_RESET} <= OUT_OFF;
            POWER_ON                             <= 1'b0;
            BUSY                                 <= 1'b0;
        end else begin
            state                                <= state_next;
            cnt                                  <= cnt_next;
            {MBC_SLEEP, MBC_ISOLATE, MBC_RESET} <= gate_ctrl(state_next);
            POWER_ON                             <= (state_next == ST_ON);
            BUSY                                 <= is_busy(state_next);
        end
    end

endmodule
